sub_window_accum: RTL and testbench

//  Downstream consumer of the subtract pipeline: accepts the signed difference

---
 rtl/sub_window_accum_pkg.sv | 23 ++
 rtl/sub_window_accum_sat_add.sv | 25 ++
 rtl/sub_window_accum.sv | 112 +++++++++++
 tb/tb_sub_window_accum.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_window_accum_pkg.sv
// Shared definitions for the windowed difference accumulator: default widths,
// FSM state encoding and the signed saturation bounds.
package sub_window_accum_pkg;

    localparam int DIN_W_DEF   = 5;
    localparam int ACC_W_DEF   = 10;
    localparam int WIN_LEN_DEF = 8;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Bounds of a w-bit two's complement value.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sub_window_accum_sat_add.sv
// Combinational signed add of an ACC_W accumulator and a sign-extended DIN_W
// sample, clamped to the ACC_W range with a flag when clamping happened.
module sat_add_signed
    import sub_window_accum_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [DIN_W-1:0] din,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;

    // One guard bit is enough: the sample is narrower than the accumulator.
    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DIN_W){din[DIN_W-1]}}, din};
    assign sat  = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum  = !sat ? wide[ACC_W-1:0] : (wide[ACC_W] ? SAT_MIN : SAT_MAX);

endmodule

// File: rtl/sub_window_accum.sv
// Sums WIN_LEN signed difference samples with saturation and hands each window
// total downstream on valid/ready, stalling upstream while a total is blocked.
module sub_window_accum
    import sub_window_accum_pkg::*;
#(
    parameter int DIN_W   = DIN_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIN_W-1:0]           subIn,
    input  logic                       subValid,
    output logic                       subReady,
    input  logic                       clrIn,
    output logic [ACC_W-1:0]           sumOut,
    output logic                       sumValid,
    input  logic                       sumReady,
    output logic                       ovfOut,
    output logic [$clog2(WIN_LEN)-1:0] winCnt
);

    localparam int               CNT_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_LEN - 1);

    state_e           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf_flag;
    logic [ACC_W-1:0] pend_sum;
    logic             pend_ovf;
    logic [ACC_W-1:0] add_sum;
    logic             add_sat;
    logic             accept, win_end, drain, out_free, flag_nxt;

    sat_add_signed #(.DIN_W(DIN_W), .ACC_W(ACC_W)) u_sat_add (
        .acc (acc),
        .din (subIn),
        .sum (add_sum),
        .sat (add_sat)
    );

    // A clear wins over a presented sample, which is then simply not taken.
    assign accept   = subValid & subReady & ~clrIn;
    assign win_end  = accept & (winCnt == LAST);
    assign drain    = sumValid & sumReady;
    assign out_free = ~sumValid | sumReady;
    assign flag_nxt = ovf_flag | add_sat;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:   if (win_end && !out_free) state_nxt = ST_STALL;
            ST_STALL: if (clrIn || drain)       state_nxt = ST_ACC;
            default:  state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        subReady = (state == ST_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            winCnt   <= '0;
            ovf_flag <= 1'b0;
        end else if (clrIn || win_end) begin
            acc      <= '0;
            winCnt   <= '0;
            ovf_flag <= 1'b0;
        end else if (accept) begin
            acc      <= add_sum;
            winCnt   <= winCnt + CNT_W'(1);
            ovf_flag <= flag_nxt;
        end
    end

    // NOTE: the pending holding register is reset too, so a discarded stall leaves no stale total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumOut   <= '0;
            ovfOut   <= 1'b0;
            sumValid <= 1'b0;
            pend_sum <= '0;
            pend_ovf <= 1'b0;
        end else begin
            if (state == ST_STALL && drain && !clrIn) begin
                sumOut   <= pend_sum;
                ovfOut   <= pend_ovf;
                sumValid <= 1'b1;
            end else if (win_end && out_free) begin
                sumOut   <= add_sum;
                ovfOut   <= flag_nxt;
                sumValid <= 1'b1;
            end else if (drain) begin
                sumValid <= 1'b0;
            end
            if (win_end && !out_free) begin
                pend_sum <= add_sum;
                pend_ovf <= flag_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sub_window_accum.sv
// Directed bench for sub_window_accum (ACC_W=6 so saturation is reachable);
// expected totals are queued at issue time and checked by a handshake monitor.
module tb_sub_window_accum;

    localparam int DIN_W   = 5;
    localparam int ACC_W   = 6;
    localparam int WIN_LEN = 8;

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIN_W-1:0] subIn = '0;
    logic             subValid = 1'b0;
    logic             subReady;
    logic             clrIn = 1'b0;
    logic [ACC_W-1:0] sumOut;
    logic             sumValid;
    logic             sumReady = 1'b1;
    logic             ovfOut;
    logic [2:0]       winCnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    sub_window_accum #(.DIN_W(DIN_W), .ACC_W(ACC_W), .WIN_LEN(WIN_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .subIn    (subIn),
        .subValid (subValid),
        .subReady (subReady),
        .clrIn    (clrIn),
        .sumOut   (sumOut),
        .sumValid (sumValid),
        .sumReady (sumReady),
        .ovfOut   (ovfOut),
        .winCnt   (winCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_sum(input int s, input int o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        q.push_back(e);
    endtask

    // Present one sample and hold it until the DUT takes it (bounded).
    task automatic send(input int v);
        int guard = 0;
        subIn    = DIN_W'(v);
        subValid = 1'b1;
        while (!subReady && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!subReady) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        subValid = 1'b0;
    endtask

    task automatic send_n(input int v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic pulse_clr();
        clrIn = 1'b1;
        @(posedge clk); #1;
        clrIn = 1'b0;
    endtask

    // Monitor: every completed output handshake must match the next queued total.
    always @(negedge clk) begin
        if (rst_n && sumValid && sumReady) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, expected none", $signed(sumOut));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum_out", int'($signed(sumOut)), e.sum);
                check("ovf_out", int'(ovfOut), e.ovf);
            end
        end
    end

    initial begin
        int mixed[8] = '{-16, 15, -1, 2, -3, 4, -5, 6};

        repeat (2) @(posedge clk);
        #1;
        check("reset_sub_ready", int'(subReady), 1);
        check("reset_sum_valid", int'(sumValid), 0);
        check("reset_sum_out", int'(sumOut), 0);
        check("reset_ovf_out", int'(ovfOut), 0);
        check("reset_win_cnt", int'(winCnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // +3 x8 with latency and counter checks
        expect_sum(24, 0);
        send_n(3, 3);
        check("t1_win_cnt_mid", int'(winCnt), 3);
        send_n(3, 5);
        check("t1_valid_latency", int'(sumValid), 1);
        check("t1_win_cnt_wrap", int'(winCnt), 0);
        wait_drain();

        // mixed signs, two windows back to back
        expect_sum(2, 0);
        expect_sum(2, 0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                send(mixed[i]);
                check("t2_no_bubble", int'(subReady), 1);
            end
        end
        wait_drain();

        // positive and negative saturation, then a clean window
        expect_sum(31, 1);
        send_n(15, 8);
        expect_sum(0, 0);
        send_n(0, 8);
        expect_sum(-32, 1);
        send_n(-16, 8);
        wait_drain();

        // back-pressure: first total held, second goes to pending
        sumReady = 1'b0;
        expect_sum(8, 0);
        expect_sum(-8, 0);
        send_n(1, 8);
        check("t4_held_valid", int'(sumValid), 1);
        send_n(-1, 8);
        check("t4_stall_ready", int'(subReady), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_held_stable", int'($signed(sumOut)), 8);
        sumReady = 1'b1;
        wait_drain();
        @(posedge clk); #1;
        check("t4_ready_back", int'(subReady), 1);
        check("t4_valid_drop", int'(sumValid), 0);

        // clear mid-window; sample presented during the clear is ignored
        send_n(2, 5);
        check("t5_cnt_before_clr", int'(winCnt), 5);
        subIn    = DIN_W'(7);
        subValid = 1'b1;
        pulse_clr();
        subValid = 1'b0;
        check("t5_cnt_after_clr", int'(winCnt), 0);
        expect_sum(8, 0);
        send_n(1, 8);
        wait_drain();

        // clear while stalled drops the pending total only
        sumReady = 1'b0;
        expect_sum(8, 0);
        send_n(1, 8);
        send_n(2, 8);
        check("t5_stalled", int'(subReady), 0);
        pulse_clr();
        check("t5_clr_ready", int'(subReady), 1);
        check("t5_clr_held_sum", int'($signed(sumOut)), 8);
        check("t5_clr_held_valid", int'(sumValid), 1);
        sumReady = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("t5_pending_dropped", int'(sumValid), 0);

        // async reset mid-window
        send_n(1, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6a_win_cnt", int'(winCnt), 0);
        check("t6a_sum_valid", int'(sumValid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("t6a_ready", int'(subReady), 1);

        // async reset mid-stall; these totals are discarded, so none are queued
        sumReady = 1'b0;
        send_n(3, 8);
        send_n(1, 8);
        check("t6b_stalled", int'(subReady), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_sum_out", int'(sumOut), 0);
        check("t6b_sum_valid", int'(sumValid), 0);
        check("t6b_ovf_out", int'(ovfOut), 0);
        check("t6b_win_cnt", int'(winCnt), 0);
        check("t6b_ready_async", int'(subReady), 1);
        sumReady = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        check("t6b_ready", int'(subReady), 1);

        expect_sum(8, 0);
        send_n(1, 8);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
